// File: rtl/tdm_mux_16.sv
// tdm_mux_16: time-division serializer for 16 single-bit channels.
// A captured 16-bit word is shifted out one channel per slot on muxOut,
// with the slot index on sel so the far-end demultiplexer can route each bit.
module tdm_mux_16 #(
    parameter int unsigned SLOT_CYCLES = 1  // clocks per slot, 1..255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] muxIn,
    input  logic        start,
    input  logic        enable,
    output logic        muxOut,
    output logic [3:0]  sel,
    output logic        frameSync,
    output logic        busy,
    output logic        done
);

    // Terminal value of the in-slot cycle counter.
    localparam logic [7:0] CntLast = 8'(SLOT_CYCLES - 1);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  slot_q, slot_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    // Last enabled cycle of a frame: final cycle of slot 15.
    logic        frame_last;
    assign frame_last = (slot_q == 4'd15) && (cnt_q == CntLast);

    // Next-state logic: frame capture, slot/cycle advance and end-of-frame handling.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && enable) begin
                    shadow_d = muxIn;
                    slot_d   = 4'd0;
                    cnt_d    = 8'd0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                // enable low freezes everything, including any pending done.
                if (enable) begin
                    if (frame_last) begin
                        done_d = 1'b1;
                        slot_d = 4'd0;
                        cnt_d  = 8'd0;
                        // start in the final cycle chains the next frame with no gap.
                        if (start) begin
                            shadow_d = muxIn;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (cnt_q < CntLast) begin
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        cnt_d  = 8'd0;
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset; reset aborts any frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            shadow_q <= 16'd0;
            slot_q   <= 4'd0;
            cnt_q    <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            slot_q   <= slot_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Outputs decoded purely from registers; no combinational input-to-output path.
    always_comb begin
        busy      = (state_q == StRun);
        sel       = slot_q;
        muxOut    = busy & shadow_q[slot_q];
        frameSync = busy && (slot_q == 4'd0) && (cnt_q == 8'd0);
        done      = done_q;
    end

endmodule
